input_filter_bank: RTL and testbench

//   Multi-channel, parametrised N-point input filter (debouncer) for raw board

---
 rtl/input_filter_bank.sv | 90 +++++++++
 tb/tb_input_filter_bank.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/input_filter_bank.sv
// Per-channel input debouncer: synchroniser, prescaled sample tick and
// consecutive-sample counter, with registered rise/fall/changed pulses.
module input_filter_bank #(
    parameter int       CHANNELS    = 4,
    parameter int       DEPTH       = 3,
    parameter int       PRESCALE    = 1,
    parameter int       SYNC_STAGES = 2,
    parameter logic     INIT        = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] in_data,
    output logic [CHANNELS-1:0] out_data,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] syncQ;
    logic [CHANNELS-1:0]                  syncOut;
    logic [PW-1:0]                        pcnt;
    logic                                 tick;
    logic [CHANNELS-1:0][CW-1:0]          cnt;
    logic [CHANNELS-1:0][CW-1:0]          cntNext;
    logic [CHANNELS-1:0]                  outNext;
    logic [CHANNELS-1:0]                  riseNext;
    logic [CHANNELS-1:0]                  fallNext;

    // Sync chain runs every cycle, independent of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ <= {(SYNC_STAGES*CHANNELS){INIT}};
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], in_data};
        end
    end

    assign syncOut = syncQ[SYNC_STAGES-1];
    assign tick    = en && (pcnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
        end
    end

    always_comb begin
        cntNext  = cnt;
        outNext  = out_data;
        riseNext = '0;
        fallNext = '0;
        if (tick) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (syncOut[c] == out_data[c]) begin
                    cntNext[c] = '0;
                end else if (cnt[c] == CW'(DEPTH - 1)) begin
                    cntNext[c]  = '0;
                    outNext[c]  = syncOut[c];
                    riseNext[c] = syncOut[c];
                    fallNext[c] = ~syncOut[c];
                end else begin
                    cntNext[c] = cnt[c] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            out_data <= {CHANNELS{INIT}};
            rise     <= '0;
            fall     <= '0;
            changed  <= 1'b0;
        end else begin
            cnt      <= cntNext;
            out_data <= outNext;
            rise     <= riseNext;
            fall     <= fallNext;
            changed  <= |(riseNext | fallNext);
        end
    end

endmodule

// File: tb/tb_input_filter_bank.sv
// Directed bench for input_filter_bank: default instance plus a
// PRESCALE=4 instance, checked through a cycle-stamped scoreboard.
module tb_input_filter_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] inA;
    logic [3:0] inB;
    logic [3:0] outA, riseA, fallA;
    logic [3:0] outB, riseB, fallB;
    logic       chgA, chgB;

    int cyc      = 0;
    int compared = 0;
    int mismatch = 0;

    typedef struct {
        int          at;
        string       tag;
        bit          d;
        logic [12:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [12:0] obs;

    input_filter_bank dutA (
        .clk(clk), .rst(rst), .en(en), .in_data(inA),
        .out_data(outA), .rise(riseA), .fall(fallA), .changed(chgA)
    );

    input_filter_bank #(.PRESCALE(4)) dutB (
        .clk(clk), .rst(rst), .en(en), .in_data(inB),
        .out_data(outB), .rise(riseB), .fall(fallB), .changed(chgB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            obs = e.d ? {outB, riseB, fallB, chgB}
                      : {outA, riseA, fallA, chgA};
            compared++;
            assert (obs === e.v && e.at == cyc) else begin
                mismatch++;
                $error("FAIL %s @%0d: observed %h required %h",
                       e.tag, e.at, obs, e.v);
            end
        end
    end

    task automatic push(input int at, input string tag, input bit d,
                        input logic [3:0] o, input logic [3:0] r,
                        input logic [3:0] f, input logic c);
        exp_t x;
        int   i = 0;
        x.at  = at;
        x.tag = tag;
        x.d   = d;
        x.v   = {o, r, f, c};
        while (i < q.size() && q[i].at <= at) i++;
        q.insert(i, x);
    endtask

    task automatic wt(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int k;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        inA = 4'hF;
        inB = 4'h0;
        wt(3);
        push(cyc, "rst_a", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(cyc, "rst_b", 1, 4'h0, 4'h0, 4'h0, 1'b0);
        wt(1);

        // Release with all inputs high: 4 quiet edges, switch on the 5th.
        rst = 1'b0;
        k = cyc;
        for (int i = 1; i <= 4; i++)
            push(k + i, "rel_quiet", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(k + 5, "rel_rise", 0, 4'hF, 4'hF, 4'h0, 1'b1);
        push(k + 6, "rel_hold", 0, 4'hF, 4'h0, 4'h0, 1'b0);
        wt(8);

        // Prescaled channel: ticks land on k+4m; a glitch between ticks.
        k = cyc;
        inB = 4'h4;
        push(k + 11, "pre_wait", 1, 4'h0, 4'h0, 4'h0, 1'b0);
        push(k + 12, "pre_rise", 1, 4'h4, 4'h4, 4'h0, 1'b1);
        push(k + 13, "pre_hold", 1, 4'h4, 4'h0, 4'h0, 1'b0);
        wt(6);
        inB = 4'h0;
        wt(1);
        inB = 4'h4;
        wt(7);

        k = cyc;
        inA = 4'h0;
        push(k + 4, "fall_wait", 0, 4'hF, 4'h0, 4'h0, 1'b0);
        push(k + 5, "fall_all", 0, 4'h0, 4'h0, 4'hF, 1'b1);
        push(k + 6, "fall_hold", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        wt(8);

        k = cyc;
        inA = 4'h1;
        push(k + 4, "step_wait", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(k + 5, "step_rise", 0, 4'h1, 4'h1, 4'h0, 1'b1);
        push(k + 5, "step_indep", 1, 4'h4, 4'h0, 4'h0, 1'b0);
        push(k + 6, "step_hold", 0, 4'h1, 4'h0, 4'h0, 1'b0);
        wt(8);

        // Two good samples, one low, then held high: count restarts.
        k = cyc;
        inA = 4'h3;
        push(k + 5, "glitch_a", 0, 4'h1, 4'h0, 4'h0, 1'b0);
        push(k + 6, "glitch_b", 0, 4'h1, 4'h0, 4'h0, 1'b0);
        push(k + 7, "glitch_c", 0, 4'h1, 4'h0, 4'h0, 1'b0);
        push(k + 8, "glitch_rise", 0, 4'h3, 4'h2, 4'h0, 1'b1);
        wt(2);
        inA = 4'h1;
        wt(1);
        inA = 4'h3;
        wt(8);

        // Freeze after two disagreeing ticks.
        k = cyc;
        inA = 4'h7;
        push(k + 5, "frz_a", 0, 4'h3, 4'h0, 4'h0, 1'b0);
        push(k + 10, "frz_b", 0, 4'h3, 4'h0, 4'h0, 1'b0);
        push(k + 14, "frz_c", 0, 4'h3, 4'h0, 4'h0, 1'b0);
        push(k + 15, "frz_rise", 0, 4'h7, 4'h4, 4'h0, 1'b1);
        push(k + 16, "frz_hold", 0, 4'h7, 4'h0, 4'h0, 1'b0);
        wt(4);
        en = 1'b0;
        wt(10);
        en = 1'b1;
        wt(4);

        // Reset one cycle before ch3 would switch.
        k = cyc;
        inA = 4'hF;
        wt(4);
        rst = 1'b1;
        push(k + 4, "mrst_async", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(k + 5, "mrst_held", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(k + 9, "mrst_wait", 0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(k + 10, "mrst_rise", 0, 4'hF, 4'hF, 4'h0, 1'b1);
        wt(1);
        rst = 1'b0;
        wt(12);

        compared++;
        assert (q.size() == 0) else begin
            mismatch++;
            $error("FAIL drain: observed %0d left required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatch);
        $finish;
    end

endmodule
